// File: rtl/tx_buffer_sequencer.sv
// Drains one buffered packet into the USB TX byte encoder over a valid/ready handshake.
// Optional stall watchdog in SEND is built only when TX_WATCHDOG_EN is defined.
module tx_buffer_sequencer #(
    parameter int MAX_PKT_BYTES  = 64,
    parameter int OCC_WIDTH      = 7,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_tx,
    input  logic                 abort,
    input  logic [OCC_WIDTH-1:0] buffer_occupancy,
    input  logic [7:0]           tx_packet_data,
    output logic                 get_tx_packet_data,
    output logic                 clear,
    output logic [7:0]           byte_out,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_error,
    output logic [OCC_WIDTH-1:0] sent_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SEND,
        DONE,
        FLUSH
    } state_t;

    localparam logic [OCC_WIDTH-1:0] MAX_LEN = OCC_WIDTH'(MAX_PKT_BYTES);

    state_t               state;
    state_t               state_next;
    logic [OCC_WIDTH-1:0] remaining;
    logic                 len_error;
    logic                 accept_start;
    logic                 wd_error;

    assign len_error    = (state == IDLE) && start_tx && (buffer_occupancy > MAX_LEN);
    assign accept_start = (state == IDLE) && start_tx && (buffer_occupancy <= MAX_LEN);

`ifdef TX_WATCHDOG_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_count;

    // The counter sits at zero outside SEND, so every entry into SEND starts a fresh stall window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (state != SEND) begin
            stall_count <= '0;
        end else if (!byte_ready) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign wd_error = (state == SEND) && !abort && !byte_ready &&
                      (stall_count == STALL_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_error = 1'b0;
`endif

    assign tx_error = (len_error || wd_error) && !rst;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_tx) begin
                    if (buffer_occupancy > MAX_LEN) begin
                        state_next = FLUSH;
                    end else if (buffer_occupancy == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH:   state_next = abort ? FLUSH : CAPTURE;
            CAPTURE: state_next = abort ? FLUSH : SEND;
            SEND: begin
                // Abort outranks a simultaneous handshake so a byte is never counted while flushing.
                if (abort) begin
                    state_next = FLUSH;
                end else if (byte_ready) begin
                    state_next = (remaining == '0) ? DONE : FETCH;
                end else if (wd_error) begin
                    state_next = FLUSH;
                end
            end
            DONE:    state_next = IDLE;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            get_tx_packet_data <= 1'b0;
            clear              <= 1'b0;
            byte_valid         <= 1'b0;
            tx_busy            <= 1'b0;
            tx_done            <= 1'b0;
        end else begin
            state              <= state_next;
            get_tx_packet_data <= (state_next == FETCH);
            clear              <= (state_next == FLUSH);
            byte_valid         <= (state_next == SEND);
            tx_busy            <= (state_next != IDLE);
            tx_done            <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining  <= '0;
            sent_count <= '0;
            byte_out   <= '0;
        end else begin
            if (accept_start) begin
                remaining  <= buffer_occupancy;
                sent_count <= '0;
            end
            if ((state == CAPTURE) && !abort) begin
                byte_out  <= tx_packet_data;
                remaining <= remaining - 1'b1;
            end
            if ((state == SEND) && byte_ready && !abort) begin
                sent_count <= sent_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/tx_buffer_sequencer.md
Name: tx_buffer_sequencer

Overview:
Controller that drains one packet's worth of bytes from the data_buffer into the USB TX byte encoder. On a start request it latches the buffer occupancy as the packet length. It then issues one get_tx_packet_data strobe per byte and presents each byte on a valid/ready handshake to the encoder. It reports done or error, and flushes the buffer via clear on abort or on a malformed length.

Parameters:
MAX_PKT_BYTES, 64, largest legal packet payload in bytes
OCC_WIDTH, 7, width of buffer_occupancy and sent_count
TIMEOUT_CYCLES, 255, stall limit in SEND (used only with TX_WATCHDOG_EN)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start_tx  input  1  single-cycle request to transmit the buffered packet
abort  input  1  cancel the current transfer and flush the buffer
buffer_occupancy  input  OCC_WIDTH  byte count reported by data_buffer
tx_packet_data  input  8  data_buffer read data, valid the cycle after a get strobe
get_tx_packet_data  output  1  one-cycle read strobe to data_buffer
clear  output  1  one-cycle flush strobe to data_buffer
byte_out  output  8  byte presented to the encoder
byte_valid  output  1  byte_out is valid
byte_ready  input  1  encoder accepts byte_out this cycle
tx_busy  output  1  high in every state except IDLE
tx_done  output  1  one-cycle pulse when the whole packet has been handed off
tx_error  output  1  one-cycle pulse on an illegal length (or a watchdog timeout)
sent_count  output  OCC_WIDTH  bytes accepted by the encoder in the current/last packet

Behaviour:
- Reset (async, rst=1): state IDLE; every output 0, including byte_out and sent_count; remaining counter 0.
- States: IDLE, FETCH, CAPTURE, SEND, DONE, FLUSH. Registered Moore outputs, decoded from state.
- IDLE:
  - start_tx=1 with buffer_occupancy > MAX_PKT_BYTES -> tx_error=1 this same cycle (Mealy pulse), next state FLUSH.
  - start_tx=1 with occupancy 0 -> DONE.
  - start_tx=1 otherwise -> remaining<=occupancy, sent_count<=0, next state FETCH.
  - abort is ignored in IDLE.
- FETCH: get_tx_packet_data=1 for exactly this cycle -> CAPTURE.
- CAPTURE: byte_out<=tx_packet_data; remaining<=remaining-1 -> SEND.
- SEND:
  - byte_valid=1; byte_out held stable until the handshake completes.
  - byte_valid&&byte_ready -> sent_count+1; if remaining==0 go DONE, else go FETCH.
- DONE: tx_done=1 for one cycle -> IDLE. sent_count holds its value until the next accepted start.
- FLUSH: clear=1 for one cycle -> IDLE.
- Throughput is at most 1 byte per 3 cycles. Minimum latency from start_tx to the first byte_valid is 3 cycles.
- start_tx while tx_busy is ignored; no queuing.
- abort in FETCH, CAPTURE or SEND -> FLUSH next cycle. No tx_done and no tx_error. A pending byte is discarded.
- abort and byte_ready in the same SEND cycle: abort wins, the byte is not counted, and sent_count does not increment.
- abort in DONE or FLUSH is ignored.
- remaining never underflows: the decrement occurs only in CAPTURE, which is entered only with remaining>=1.
- buffer_occupancy changes after start are ignored; only the latched length is used.

Optional Feature:
TX_WATCHDOG_EN:
- Defined: a stall counter clears on entry to SEND and increments on each SEND cycle with byte_ready=0. When it reaches TIMEOUT_CYCLES, tx_error pulses for one cycle and the next state is FLUSH. The counter also resets on rst.
- Undefined: no counter is built, and SEND waits indefinitely for byte_ready.

Test Plan:
- Reset: assert rst mid-SEND of a 3-byte packet -> all outputs 0 immediately (async), state IDLE after release, no clear pulse.
- Nominal 3-byte packet (buffer holds A1,B2,C3; occupancy 3; byte_ready tied 1):
  - exactly 3 get pulses, 3 cycles apart;
  - byte_out sequence A1,B2,C3 with first byte_valid 3 cycles after start;
  - tx_done 1 cycle after the third handshake; sent_count=3.
- Zero length: occupancy 0 + start_tx -> no get strobe, tx_done high the cycle after start, sent_count=0.
- Backpressure: 2-byte packet 5A,C3 with byte_ready low for 6 cycles on the first byte -> byte_valid held, byte_out=5A stable, no extra get; packet completes normally once ready returns.
- Abort and illegal length:
  - abort asserted together with byte_ready on byte 2 of 4 -> sent_count=1, clear pulses once next cycle, no tx_done or tx_error;
  - start with occupancy 65 -> tx_error on the start cycle, clear the following cycle.
- Watchdog (macro defined, TIMEOUT_CYCLES=8): byte_ready held 0 -> tx_error after 8 stalled cycles, then clear; with macro undefined -> byte_valid stays high for 50+ cycles.
